writeback_retire_unit: RTL and testbench

Parametrised in-order write-back/retire stage that replaces the single-lane write-back stage for multi-issue pipeline builds. It accepts bundles of up to LANES completed instructions from MEM/WB and buffers them in a DEPTH-entry retire queue. It retires them in program order to LANES GPR write ports and services syscalls (print_int with a console handshake, exit) and arithmetic-overflow exceptions as precise halts. It sits between the MEM/WB register and the GPR file/testbench console.

---
 rtl/wb_pkg.sv | 39 +++
 rtl/retire_queue.sv | 71 +++++++
 rtl/writeback_retire_unit.sv | 269 ++++++++++++++++++++++++++
 tb/tb_writeback_retire_unit.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg
// Shared types for the multi-lane write-back/retire stage.
//   WbEntry   : one completed instruction as held in the retire queue
//   HaltCause : encoding of the sticky halt cause output
//   WbState   : retire FSM states
//   SYS_*     : syscall numbers recognised in $v0
// -----------------------------------------------------------------------------
package wb_pkg;

    localparam logic [31:0] SYS_PRINT_INT = 32'd1;
    localparam logic [31:0] SYS_EXIT      = 32'd10;

    // "reg" is a keyword, so the destination register field is named rd.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic [31:0] v0;
        logic [31:0] a0;
        logic [4:0]  rd;
        logic        wen;
        logic        syscall;
        logic        exc;
    } WbEntry;

    typedef enum logic [1:0] {
        CauseNone       = 2'd0,
        CauseExit       = 2'd1,
        CauseOverflow   = 2'd2,
        CauseBadSyscall = 2'd3
    } HaltCause;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StPrint  = 2'd1,
        StHalted = 2'd2
    } WbState;

endpackage

// File: rtl/retire_queue.sv
// -----------------------------------------------------------------------------
// retire_queue
// In-order circular FIFO of WbEntry with up to LANES pushes and LANES pops
// per cycle. The head window always shows the LANES oldest slots; entries
// beyond o_count are stale and must be ignored by the consumer.
//   clock, reset     : clock, asynchronous active-low reset
//   i_flush          : discard all contents (wins over push/pop)
//   i_push_count     : number of entries taken from i_push_entries[0..]
//   i_push_entries   : compacted entries to append
//   i_pop_count      : number of head entries to drop
//   o_head           : LANES oldest slots, oldest at index 0
//   o_count          : registered occupancy
// -----------------------------------------------------------------------------
module retire_queue
    import wb_pkg::*;
#(
    parameter int unsigned LANES = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         i_flush,
    input  logic [$clog2(LANES+1)-1:0]   i_push_count,
    input  WbEntry [LANES-1:0]           i_push_entries,
    input  logic [$clog2(LANES+1)-1:0]   i_pop_count,
    output WbEntry [LANES-1:0]           o_head,
    output logic [$clog2(DEPTH):0]       o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(LANES + 1);
    localparam int QW = PW + 1;

    WbEntry           r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [QW-1:0]    r_count;

    always_ff @(posedge clock) begin
        for (int i = 0; i < LANES; i++) begin
            if (CW'(i) < i_push_count) begin
                r_mem[r_wptr + PW'(i)] <= i_push_entries[i];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            r_wptr  <= r_wptr + PW'(i_push_count);
            r_rptr  <= r_rptr + PW'(i_pop_count);
            r_count <= r_count + QW'(i_push_count) - QW'(i_pop_count);
        end
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            o_head[i] = r_mem[r_rptr + PW'(i)];
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/writeback_retire_unit.sv
// -----------------------------------------------------------------------------
// writeback_retire_unit
// Multi-lane in-order write-back/retire stage. Buffers bundles from MEM/WB in
// a retire queue, retires ordinary entries to LANES GPR write ports, services
// print_int/exit syscalls and halts precisely on overflow.
// Optional feature macro: WB_TRACE_EN (text trace of retirement plus $finish
// one cycle after the halt; simulation only).
// Ports:
//   clock, reset                 : clock, asynchronous active-low reset
//   inValid/inReady, inCount     : bundle handshake and valid lane count
//   inPc/inData/inV0/inA0/inReg  : per-lane packed instruction fields
//   inWen/inSyscall/inExc        : per-lane flags
//   gprWrite*                    : registered GPR write ports, port 0 oldest
//   printValid/printValue/Ready  : print_int console handshake
//   halted/haltCause/haltPc      : sticky halt status
//   retiredCount                 : entries popped since reset (wraps)
//   traceFile                    : trace descriptor (WB_TRACE_EN only)
// -----------------------------------------------------------------------------
module writeback_retire_unit
    import wb_pkg::*;
#(
    parameter int unsigned LANES = 2,
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         inValid,
    output logic                         inReady,
    input  logic [$clog2(LANES+1)-1:0]   inCount,
    input  logic [LANES*32-1:0]          inPc,
    input  logic [LANES*32-1:0]          inData,
    input  logic [LANES*32-1:0]          inV0,
    input  logic [LANES*32-1:0]          inA0,
    input  logic [LANES*5-1:0]           inReg,
    input  logic [LANES-1:0]             inWen,
    input  logic [LANES-1:0]             inSyscall,
    input  logic [LANES-1:0]             inExc,
    output logic [LANES-1:0]             gprWriteEnabled,
    output logic [LANES*5-1:0]           gprWriteRegister,
    output logic [LANES*32-1:0]          gprWriteInput,
    output logic                         printValid,
    output logic [31:0]                  printValue,
    input  logic                         printReady,
    output logic                         halted,
    output logic [1:0]                   haltCause,
    output logic [31:0]                  haltPc,
    output logic [31:0]                  retiredCount,
    input  integer                       traceFile
);

    localparam int CW = $clog2(LANES + 1);
    localparam int QW = $clog2(DEPTH) + 1;

    WbState               r_state;
    WbState               w_state_next;
    HaltCause             r_halt_cause;
    HaltCause             w_cause_next;
    logic [31:0]          r_halt_pc;
    logic [31:0]          w_halt_pc_next;
    logic [31:0]          r_retired;
    logic [LANES-1:0]     r_we;
    logic [LANES*5-1:0]   r_reg;
    logic [LANES*32-1:0]  r_data;
    logic [LANES-1:0]     w_we_next;
    logic [LANES*5-1:0]   w_reg_next;
    logic [LANES*32-1:0]  w_data_next;

    WbEntry [LANES-1:0]   w_lane;
    WbEntry [LANES-1:0]   w_push_entries;
    WbEntry [LANES-1:0]   w_head;
    logic [CW-1:0]        w_push_count;
    logic [CW-1:0]        w_q_push_count;
    logic [CW-1:0]        w_pop_count;
    logic [QW-1:0]        w_occ;
    logic                 w_push;
    logic                 w_halt_now;

    // Ready depends only on registered state, never on this cycle's pops.
    assign inReady = reset && (r_state != StHalted) && (w_occ <= QW'(DEPTH - LANES));
    assign w_push  = inValid && inReady;

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            w_lane[i] = '{
                pc:      inPc[i*32 +: 32],
                data:    inData[i*32 +: 32],
                v0:      inV0[i*32 +: 32],
                a0:      inA0[i*32 +: 32],
                rd:      inReg[i*5 +: 5],
                wen:     inWen[i],
                syscall: inSyscall[i],
                exc:     inExc[i]
            };
        end
    end

    // Compact live lanes towards slot 0, dropping PC==0 bubbles.
    always_comb begin
        int k;
        k = 0;
        w_push_entries = '0;
        for (int i = 0; i < LANES; i++) begin
            if (CW'(i) < inCount && w_lane[i].pc != 32'h0) begin
                for (int j = 0; j < LANES; j++) begin
                    if (j == k) begin
                        w_push_entries[j] = w_lane[i];
                    end
                end
                k = k + 1;
            end
        end
        w_push_count = CW'(k);
    end

    assign w_q_push_count = w_push ? w_push_count : '0;

    retire_queue #(
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) u_retire_queue (
        .clock          (clock),
        .reset          (reset),
        .i_flush        (w_halt_now),
        .i_push_count   (w_q_push_count),
        .i_push_entries (w_push_entries),
        .i_pop_count    (w_pop_count),
        .o_head         (w_head),
        .o_count        (w_occ)
    );

    // Retire FSM: next state, pop count and write-port contents.
    always_comb begin
        int   n;
        logic stop;
        w_state_next   = r_state;
        w_pop_count    = '0;
        w_halt_now     = 1'b0;
        w_cause_next   = r_halt_cause;
        w_halt_pc_next = r_halt_pc;
        w_we_next      = '0;
        w_reg_next     = '0;
        w_data_next    = '0;
        n              = 0;
        stop           = 1'b0;
        case (r_state)
            StRun: begin
                if (w_occ != '0) begin
                    if (w_head[0].exc) begin
                        w_pop_count    = CW'(1);
                        w_halt_now     = 1'b1;
                        w_state_next   = StHalted;
                        w_cause_next   = CauseOverflow;
                        w_halt_pc_next = w_head[0].pc;
                    end else if (w_head[0].syscall) begin
                        if (w_head[0].v0 == SYS_PRINT_INT) begin
                            w_state_next = StPrint;
                        end else begin
                            w_pop_count    = CW'(1);
                            w_halt_now     = 1'b1;
                            w_state_next   = StHalted;
                            w_cause_next   = (w_head[0].v0 == SYS_EXIT) ? CauseExit
                                                                        : CauseBadSyscall;
                            w_halt_pc_next = w_head[0].pc;
                        end
                    end else begin
                        // Longest run of ordinary entries from the head.
                        for (int i = 0; i < LANES; i++) begin
                            if (!stop && QW'(i) < w_occ && !w_head[i].syscall
                                    && !w_head[i].exc) begin
                                n = n + 1;
                            end else begin
                                stop = 1'b1;
                            end
                        end
                        w_pop_count = CW'(n);
                        for (int i = 0; i < LANES; i++) begin
                            if (i < n && w_head[i].wen && w_head[i].rd != 5'd0) begin
                                w_we_next[i] = 1'b1;
                                // A younger write to the same register in this group wins.
                                for (int j = i + 1; j < LANES; j++) begin
                                    if (j < n && w_head[j].wen && w_head[j].rd == w_head[i].rd) begin
                                        w_we_next[i] = 1'b0;
                                    end
                                end
                            end
                            if (w_we_next[i]) begin
                                w_reg_next[i*5 +: 5]   = w_head[i].rd;
                                w_data_next[i*32 +: 32] = w_head[i].data;
                            end
                        end
                    end
                end
            end
            StPrint: begin
                if (printReady) begin
                    w_pop_count  = CW'(1);
                    w_state_next = StRun;
                end
            end
            StHalted: begin
                w_state_next = StHalted;
            end
            default: begin
                w_state_next = StRun;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= StRun;
            r_halt_cause <= CauseNone;
            r_halt_pc    <= '0;
            r_retired    <= '0;
            r_we         <= '0;
            r_reg        <= '0;
            r_data       <= '0;
        end else begin
            r_state      <= w_state_next;
            r_halt_cause <= w_cause_next;
            r_halt_pc    <= w_halt_pc_next;
            r_retired    <= r_retired + 32'(w_pop_count);
            r_we         <= w_we_next;
            r_reg        <= w_reg_next;
            r_data       <= w_data_next;
        end
    end

    assign gprWriteEnabled  = r_we;
    assign gprWriteRegister = r_reg;
    assign gprWriteInput    = r_data;
    assign printValid       = (r_state == StPrint);
    assign printValue       = printValid ? w_head[0].a0 : 32'h0;
    assign halted           = (r_state == StHalted);
    assign haltCause        = r_halt_cause;
    assign haltPc           = r_halt_pc;
    assign retiredCount     = r_retired;

`ifdef WB_TRACE_EN
    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LANES; i++) begin
                if (w_we_next[i]) begin
                    $display("@%h: $%0d <= %h", w_head[i].pc, w_head[i].rd, w_head[i].data);
                end
            end
            if (r_state == StPrint && printReady) begin
                $display("%0d", w_head[0].a0);
            end
            if (w_halt_now) begin
                if (w_cause_next == CauseOverflow) begin
                    $display("Runtime exception at %h: arithmetic overflow", w_halt_pc_next);
                end else if (w_cause_next == CauseExit) begin
                    $display("exit at %h", w_halt_pc_next);
                end else begin
                    $display("bad syscall at %h", w_halt_pc_next);
                end
            end
            if (r_state == StHalted) begin
                $finish;
            end
        end
    end
`else
    logic w_unused_trace;
    assign w_unused_trace = ^traceFile;
`endif

endmodule

// File: tb/tb_writeback_retire_unit.sv
module tb_writeback_retire_unit;
    localparam int LANES = 2;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(LANES + 1);

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic [31:0] v0;
        logic [31:0] a0;
        logic [4:0]  rd;
        logic        wen;
        logic        sys;
        logic        exc;
    } ent_t;

    logic                 clock;
    logic                 reset;
    logic                 inValid;
    logic                 inReady;
    logic [CW-1:0]        inCount;
    logic [LANES*32-1:0]  inPc;
    logic [LANES*32-1:0]  inData;
    logic [LANES*32-1:0]  inV0;
    logic [LANES*32-1:0]  inA0;
    logic [LANES*5-1:0]   inReg;
    logic [LANES-1:0]     inWen;
    logic [LANES-1:0]     inSyscall;
    logic [LANES-1:0]     inExc;
    logic [LANES-1:0]     gprWriteEnabled;
    logic [LANES*5-1:0]   gprWriteRegister;
    logic [LANES*32-1:0]  gprWriteInput;
    logic                 printValid;
    logic [31:0]          printValue;
    logic                 printReady;
    logic                 halted;
    logic [1:0]           haltCause;
    logic [31:0]          haltPc;
    logic [31:0]          retiredCount;
    integer               traceFile;

    writeback_retire_unit #(
        .LANES (LANES),
        .DEPTH (DEPTH)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .inValid          (inValid),
        .inReady          (inReady),
        .inCount          (inCount),
        .inPc             (inPc),
        .inData           (inData),
        .inV0             (inV0),
        .inA0             (inA0),
        .inReg            (inReg),
        .inWen            (inWen),
        .inSyscall        (inSyscall),
        .inExc            (inExc),
        .gprWriteEnabled  (gprWriteEnabled),
        .gprWriteRegister (gprWriteRegister),
        .gprWriteInput    (gprWriteInput),
        .printValid       (printValid),
        .printValue       (printValue),
        .printReady       (printReady),
        .halted           (halted),
        .haltCause        (haltCause),
        .haltPc           (haltPc),
        .retiredCount     (retiredCount),
        .traceFile        (traceFile)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          checks;
    int          failures;
    // Reference model: a plain queue of in-flight instructions plus halt/print status.
    ent_t        mq[$];
    bit          m_print;
    bit          m_halted;
    logic [1:0]  m_cause;
    logic [31:0] m_hpc;
    logic [31:0] m_ret;
    logic [31:0] tot_pushed;
    ent_t        bl[LANES];
    int          pv_cycles;
    bit          saw_block;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_bundle();
        for (int i = 0; i < LANES; i++) begin
            bl[i] = '{pc: 32'h0, data: 32'h0, v0: 32'h0, a0: 32'h0, rd: 5'd0,
                      wen: 1'b0, sys: 1'b0, exc: 1'b0};
        end
    endtask

    task automatic lane(input int i, input logic [31:0] pc, input logic [4:0] rd,
                        input logic [31:0] data, input logic wen, input logic sys,
                        input logic exc, input logic [31:0] v0, input logic [31:0] a0);
        bl[i] = '{pc: pc, data: data, v0: v0, a0: a0, rd: rd, wen: wen, sys: sys, exc: exc};
    endtask

    task automatic model_halt(input logic [1:0] cause);
        m_halted = 1'b1;
        m_cause  = cause;
        m_hpc    = mq[0].pc;
        void'(mq.pop_front());
        m_ret    = m_ret + 32'd1;
    endtask

    // One clock: drive, check pre-edge outputs, advance model, check post-edge outputs.
    task automatic step();
        logic [LANES-1:0] ew;
        logic [4:0]       er[LANES];
        logic [31:0]      ed[LANES];
        bit               acc;
        bit               exp_ready;
        bit               halt_now;
        int               n;
        for (int i = 0; i < LANES; i++) begin
            inPc[i*32 +: 32]   = bl[i].pc;
            inData[i*32 +: 32] = bl[i].data;
            inV0[i*32 +: 32]   = bl[i].v0;
            inA0[i*32 +: 32]   = bl[i].a0;
            inReg[i*5 +: 5]    = bl[i].rd;
            inWen[i]           = bl[i].wen;
            inSyscall[i]       = bl[i].sys;
            inExc[i]           = bl[i].exc;
            er[i]              = 5'd0;
            ed[i]              = 32'h0;
        end
        #1;
        exp_ready = !m_halted && ((DEPTH - mq.size()) >= LANES);
        check("inReady", 32'(inReady), 32'(exp_ready));
        check("printValid", 32'(printValid), 32'(m_print));
        if (m_print) check("printValue", printValue, mq[0].a0);
        if (printValid) pv_cycles++;
        if (!inReady) saw_block = 1'b1;
        acc      = inValid && exp_ready;
        ew       = '0;
        halt_now = 1'b0;
        if (m_print) begin
            if (printReady) begin
                void'(mq.pop_front());
                m_ret   = m_ret + 32'd1;
                m_print = 1'b0;
            end
        end else if (!m_halted && mq.size() > 0) begin
            if (mq[0].exc) begin
                model_halt(2'd2);
                halt_now = 1'b1;
            end else if (mq[0].sys) begin
                if (mq[0].v0 == 32'd1) begin
                    m_print = 1'b1;
                end else begin
                    model_halt((mq[0].v0 == 32'd10) ? 2'd1 : 2'd3);
                    halt_now = 1'b1;
                end
            end else begin
                n = 0;
                while (n < LANES && n < mq.size() && !mq[n].sys && !mq[n].exc) n++;
                for (int k = 0; k < n; k++) begin
                    ew[k] = mq[k].wen && (mq[k].rd != 5'd0);
                    for (int j = k + 1; j < n; j++) begin
                        if (mq[j].wen && mq[j].rd == mq[k].rd) ew[k] = 1'b0;
                    end
                    er[k] = mq[k].rd;
                    ed[k] = mq[k].data;
                end
                for (int k = 0; k < n; k++) void'(mq.pop_front());
                m_ret = m_ret + 32'(n);
            end
        end
        if (acc) begin
            for (int i = 0; i < LANES; i++) begin
                if (i < int'(inCount) && bl[i].pc != 32'h0) begin
                    mq.push_back(bl[i]);
                    tot_pushed = tot_pushed + 32'd1;
                end
            end
        end
        if (halt_now) mq.delete();
        @(posedge clock);
        #1;
        check("we", 32'(gprWriteEnabled), 32'(ew));
        for (int k = 0; k < LANES; k++) begin
            if (ew[k]) begin
                check("wreg", 32'(gprWriteRegister[k*5 +: 5]), 32'(er[k]));
                check("wdata", gprWriteInput[k*32 +: 32], ed[k]);
            end
        end
        check("halted", 32'(halted), 32'(m_halted));
        check("haltCause", 32'(haltCause), 32'(m_cause));
        check("haltPc", haltPc, m_hpc);
        check("retired", retiredCount, m_ret);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        inValid = 1'b0;
        #1;
        check("rst_we", 32'(gprWriteEnabled), 32'h0);
        check("rst_pv", 32'(printValid), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_cause", 32'(haltCause), 32'h0);
        check("rst_pc", haltPc, 32'h0);
        check("rst_ret", retiredCount, 32'h0);
        check("rst_ready", 32'(inReady), 32'h0);
        mq.delete();
        m_print    = 1'b0;
        m_halted   = 1'b0;
        m_cause    = 2'd0;
        m_hpc      = 32'h0;
        m_ret      = 32'h0;
        tot_pushed = 32'h0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rel_ready", 32'(inReady), 32'h1);
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        traceFile  = 0;
        reset      = 1'b0;
        inValid    = 1'b0;
        inCount    = '0;
        printReady = 1'b1;
        pv_cycles  = 0;
        saw_block  = 1'b0;
        tot_pushed = 32'h0;
        clear_bundle();
        do_reset();

        // Two independent writes retire together.
        lane(0, 32'h0040_0000, 5'd8, 32'd1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        lane(1, 32'h0040_0004, 5'd9, 32'd2, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        inValid = 1'b1; inCount = CW'(2);
        step();
        inValid = 1'b0;
        step();
        check("t1_we", 32'(gprWriteEnabled), 32'h3);
        check("t1_reg1", 32'(gprWriteRegister[9:5]), 32'd9);
        check("t1_ret", retiredCount, 32'd2);

        // Same destination in one group: only the younger port writes.
        lane(0, 32'h0040_0008, 5'd5, 32'h0000_00AA, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        lane(1, 32'h0040_000C, 5'd5, 32'h0000_00BB, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        inValid = 1'b1;
        step();
        inValid = 1'b0;
        step();
        check("t2_we", 32'(gprWriteEnabled), 32'h2);
        check("t2_reg", 32'(gprWriteRegister[9:5]), 32'd5);
        check("t2_data", gprWriteInput[63:32], 32'h0000_00BB);

        // print_int with a stalled console holds younger entries.
        printReady = 1'b0;
        lane(0, 32'h0040_0100, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd1, 32'd42);
        lane(1, 32'h0040_0104, 5'd3, 32'd7, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        pv_cycles = 0;
        inValid = 1'b1;
        step();
        inValid = 1'b0;
        step();
        step();
        step();
        step();
        printReady = 1'b1;
        step();
        step();
        check("t3_pvcycles", 32'(pv_cycles), 32'd4);
        check("t3_we", 32'(gprWriteEnabled), 32'h1);
        check("t3_reg", 32'(gprWriteRegister[4:0]), 32'd3);

        // Fill the queue behind a stalled print, then drain.
        do_reset();
        printReady = 1'b0;
        saw_block  = 1'b0;
        lane(0, 32'h0040_0200, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd1, 32'd99);
        lane(1, 32'h0040_0204, 5'd10, 32'd100, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        inValid = 1'b1; inCount = CW'(2);
        step();
        for (int b = 0; b < 6; b++) begin
            lane(0, 32'h0040_0300 + 32'(b * 8), 5'(11 + b), 32'(200 + b), 1'b1, 1'b0, 1'b0,
                 32'd0, 32'd0);
            lane(1, 32'h0040_0304 + 32'(b * 8), 5'(20 + b), 32'(300 + b), 1'b1, 1'b0, 1'b0,
                 32'd0, 32'd0);
            step();
        end
        check("t4_blocked", 32'(saw_block), 32'h1);
        inValid    = 1'b0;
        printReady = 1'b1;
        for (int c = 0; c < 40 && (mq.size() > 0 || m_print); c++) step();
        step();
        check("t4_drain_ready", 32'(inReady), 32'h1);
        check("t4_no_loss", retiredCount, tot_pushed);

        // Reset while a print is pending.
        printReady = 1'b0;
        lane(0, 32'h0040_0400, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd1, 32'd5);
        lane(1, 32'h0040_0404, 5'd4, 32'd6, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        inValid = 1'b1;
        step();
        inValid = 1'b0;
        step();
        step();
        do_reset();
        printReady = 1'b1;
        step();
        check("t5_pv", 32'(printValid), 32'h0);
        check("t5_ret", retiredCount, 32'h0);

        // Overflow on lane 1: older write retires, halt is precise.
        lane(0, 32'h0040_000C, 5'd4, 32'h11, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        lane(1, 32'h0040_0010, 5'd6, 32'h22, 1'b1, 1'b0, 1'b1, 32'd0, 32'd0);
        inValid = 1'b1; inCount = CW'(2);
        step();
        inValid = 1'b0;
        step();
        check("t6_we0", 32'(gprWriteEnabled), 32'h1);
        step();
        check("t6_we_supp", 32'(gprWriteEnabled), 32'h0);
        check("t6_halted", 32'(halted), 32'h1);
        check("t6_cause", 32'(haltCause), 32'd2);
        check("t6_pc", haltPc, 32'h0040_0010);
        check("t6_ready", 32'(inReady), 32'h0);
        inValid = 1'b1;
        step();
        inValid = 1'b0;
        step();
        do_reset();

        // Exit and unknown syscall.
        clear_bundle();
        lane(0, 32'h0040_0500, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd10, 32'd0);
        inValid = 1'b1; inCount = CW'(1);
        step();
        inValid = 1'b0;
        step();
        check("t7_cause", 32'(haltCause), 32'd1);
        check("t7_pc", haltPc, 32'h0040_0500);
        do_reset();
        lane(0, 32'h0040_0600, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0, 32'd7, 32'd0);
        inValid = 1'b1;
        step();
        inValid = 1'b0;
        step();
        check("t8_cause", 32'(haltCause), 32'd3);
        check("t8_ret", retiredCount, 32'd1);
        do_reset();

        // Bubble in lane 0 is dropped; lane 1 retires on port 0.
        lane(0, 32'h0, 5'd7, 32'd1, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        lane(1, 32'h0040_0700, 5'd12, 32'h77, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        inValid = 1'b1; inCount = CW'(2);
        step();
        inValid = 1'b0;
        step();
        check("t9_we", 32'(gprWriteEnabled), 32'h1);
        check("t9_data", gprWriteInput[31:0], 32'h77);
        check("t9_ret", retiredCount, 32'd1);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            int r;
            for (int i = 0; i < LANES; i++) begin
                r = int'($urandom_range(0, 99));
                bl[i].pc   = ($urandom_range(0, 7) == 0) ? 32'h0
                           : 32'h0040_0000 + ($urandom & 32'h0000_fffc);
                bl[i].rd   = 5'($urandom_range(0, 7));
                bl[i].data = $urandom;
                bl[i].wen  = ($urandom_range(0, 3) != 0);
                bl[i].sys  = (r < 8);
                bl[i].exc  = (r == 99);
                bl[i].v0   = (r < 6) ? 32'd1 : ((r == 6) ? 32'd10 : 32'd3);
                bl[i].a0   = $urandom;
            end
            inCount    = CW'($urandom_range(0, LANES));
            inValid    = ($urandom_range(0, 3) != 0);
            printReady = ($urandom_range(0, 2) != 0);
            step();
            if (m_halted) begin
                inValid = 1'b1;
                step();
                step();
                do_reset();
            end
        end
        inValid    = 1'b0;
        printReady = 1'b1;
        for (int c = 0; c < 40 && (mq.size() > 0 || m_print); c++) step();
        step();
        check("rand_drain", retiredCount, tot_pushed);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
